// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory wait-state responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - bus word width and byte-offset width
//   - wait-counter width and a helper that sizes the terminal count
package dmem_bus_pkg;

   localparam int WORD_W        = 32;
   localparam int BYTE_OFFSET_W = 2;
   localparam int WAIT_CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Terminal count for the wait counter, truncated to the counter width
   // (WAIT_STATES is limited to 0..15, so nothing is lost).
   function automatic logic [WAIT_CNT_W-1:0] wait_limit(input int wait_states);
      return WAIT_CNT_W'(wait_states);
   endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Wait-state counter for the data-memory responder.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears the count
//   load      start a wait period: count becomes 1
//   clear     drop the count back to 0 (abort or leaving WAIT)
//   count_en  advance the count by one
//   done      count has reached WAIT_STATES
module dmem_wait_counter
   import dmem_bus_pkg::*;
#(
   parameter int WAIT_STATES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic clear,
   input  logic count_en,
   output logic done
);

   localparam logic [WAIT_CNT_W-1:0] LIMIT = wait_limit(WAIT_STATES);

   logic [WAIT_CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= WAIT_CNT_W'(1);
      end else if (count_en) begin
         count <= count + WAIT_CNT_W'(1);
      end
   end

   assign done = (count == LIMIT);

endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the MIPS core data bus with fixed wait states.
// A request (memwrite/memread with dataadr/writedata) is latched in IDLE,
// spends WAIT_STATES cycles in WAIT and completes with a one-cycle ready
// pulse in RESP. Reads return the stored word during RESP; writes commit at
// the RESP edge. Out-of-range addresses and simultaneous read+write complete
// with err=1 and have no effect on the memory.
//
// Optional build macro: ALIGN_CHECK_EN
//   defined   - addr[1:0] != 0 completes with err=1, no write, readdata=0
//   undefined - addr[1:0] ignored, access goes to the word at idx
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (memory contents are kept)
//   memwrite   write request, held until ready or abort
//   memread    read request, held until ready or abort
//   dataadr    byte address
//   writedata  write word
//   readdata   read word, valid only while ready=1 for a read, 0 otherwise
//   ready      one-cycle completion pulse
//   err        completion with error, only together with ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; latches address/data/direction
// WAIT  | counting wait states 1..WAIT_STATES; request drop aborts
// RESP  | ready=1 for one cycle; write commits here when err=0
module dmem_wait_responder
   import dmem_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                memwrite,
   input  logic                memread,
   input  logic [WORD_W-1:0]   dataadr,
   input  logic [WORD_W-1:0]   writedata,
   output logic [WORD_W-1:0]   readdata,
   output logic                ready,
   output logic                err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int HI_LO = IDX_W + BYTE_OFFSET_W;

   dmem_state_t state, state_nx;

   logic              req;
   logic              out_of_range;
   logic              misaligned;
   logic              req_err;
   logic              sample;

   logic [IDX_W-1:0]  lat_idx;
   logic [WORD_W-1:0] lat_wdata;
   logic              lat_wr;
   logic              lat_rd;
   logic              lat_err;

   logic              cnt_load;
   logic              cnt_clear;
   logic              cnt_en;
   logic              cnt_done;

   logic              mem_we;
   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   assign req          = memwrite | memread;
   assign out_of_range = |dataadr[WORD_W-1:HI_LO];

`ifdef ALIGN_CHECK_EN
   assign misaligned = |dataadr[BYTE_OFFSET_W-1:0];
`else
   logic unused_byte_ofs;
   assign misaligned      = 1'b0;
   assign unused_byte_ofs = ^dataadr[BYTE_OFFSET_W-1:0];
`endif

   assign req_err = (memwrite & memread) | out_of_range | misaligned;
   assign sample  = (state == IDLE) && req;

   // ---------------------------------------------------------------
   // Request latch: everything the response needs is captured in IDLE
   // so the core is free to change the bus afterwards.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
         lat_rd    <= 1'b0;
         lat_err   <= 1'b0;
      end else if (sample) begin
         lat_idx   <= dataadr[HI_LO-1:BYTE_OFFSET_W];
         lat_wdata <= writedata;
         lat_wr    <= memwrite;
         lat_rd    <= memread;
         lat_err   <= req_err;
      end
   end

   // ---------------------------------------------------------------
   // Wait-state counter
   // ---------------------------------------------------------------
   dmem_wait_counter #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .done     (cnt_done)
   );

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_load  = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_load = 1'b1;
               end
            end
         end
         WAIT: begin
            // A dropped request wins over the terminal count.
            if (!req) begin
               state_nx  = IDLE;
               cnt_clear = 1'b1;
            end else if (cnt_done) begin
               state_nx  = RESP;
               cnt_clear = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx  = IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Response outputs
   // ---------------------------------------------------------------
   assign ready    = (state == RESP);
   assign err      = ready & lat_err;
   assign readdata = (ready && lat_rd && !lat_err) ? mem[lat_idx] : '0;

   // ---------------------------------------------------------------
   // Memory array: no reset, contents survive reset. A reset landing on
   // the RESP edge discards the pending write.
   // ---------------------------------------------------------------
   assign mem_we = ready && lat_wr && !lat_err && !reset;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

endmodule
